// File: rtl/toggle_cover_pkg.sv
// toggle_cover_pkg: shared FSM states, default index width and popcount helper
package toggle_cover_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;
    localparam int IDX_W_DEF = 64;
    localparam int POP_W = 256;
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        popcount = 0;
        for (int i = 0; i < POP_W; i++) popcount += {31'd0, v[i]};
    endfunction
endpackage

// File: rtl/toggle_cover_scheduler_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping from N-1 back to 0
module rr_pick #(
    parameter int N = 20,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] sel,
    output logic             any
);
    int j;
    // scan downward so the closest request to ptr is the last assignment
    always_comb begin
        sel = ptr;
        j = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j -= N;
            if (req[j[PTR_W-1:0]]) sel = j[PTR_W-1:0];
        end
    end
    assign any = |req;
endmodule

// File: rtl/toggle_cover_scheduler.sv
// toggle_cover_scheduler: sticky first-hit recording with round-robin export of cover events
module toggle_cover_scheduler
    import toggle_cover_pkg::*;
#(
    parameter int N = 20,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     valid,
    input  logic             clear_req,
    output logic             clear_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    state_t state;
    logic [N-1:0] covered, pending, hits, drop, pending_left;
    logic [PTR_W-1:0] ptr, pick_sel, sel, held_sel;
    logic held, any, fire;

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req(pending),
        .ptr(ptr),
        .sel(pick_sel),
        .any(any)
    );

    // a stalled offer keeps its index even if closer bits become pending
    assign sel = held ? held_sel : pick_sel;
    assign out_valid = any && state != CLEAR;
    assign fire = out_valid && out_ready;
    assign out_index = IDX_W'(COVER_INDEX) + IDX_W'(out_valid ? sel : ptr);
    assign clear_ack = state == CLEAR;
    assign all_covered = covered_count == CNT_W'(N);
    assign hits = (state == RUN) ? valid & ~covered : '0;
    assign drop = fire ? N'(1) << sel : '0;
    assign pending_left = pending & ~drop;

    // coverage bookkeeping, handshake retirement and drain/clear sequencing
    always_ff @(posedge clock) begin
        if (reset || state == CLEAR) begin
            state <= RUN;
            covered <= '0;
            pending <= '0;
            ptr <= '0;
            covered_count <= '0;
            held <= 1'b0;
            held_sel <= '0;
        end else begin
            covered <= covered | hits;
            pending <= pending_left | hits;
            covered_count <= covered_count + CNT_W'(popcount(POP_W'(hits)));
            held <= out_valid && !out_ready;
            held_sel <= sel;
            if (fire) ptr <= (sel == PTR_W'(N - 1)) ? '0 : sel + 1'b1;
            if (state == RUN && clear_req) state <= DRAIN;
            else if (state == DRAIN && pending_left == '0) state <= CLEAR;
        end
    end
endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// tb_toggle_cover_scheduler: directed vector table, corner sequences and random run against a reference model
module tb_toggle_cover_scheduler;
    localparam int N = 20;
    localparam longint unsigned CI = 100;
    localparam int CNT_W = $clog2(N + 1);

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] valid = '0;
    logic clear_req = 1'b0;
    logic out_ready = 1'b0;
    logic clear_ack, out_valid, all_covered;
    logic [63:0] out_index;
    logic [CNT_W-1:0] covered_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic rst;
        logic [N-1:0] v;
        logic cr;
        logic rdy;
        logic ev;
        int ei;
        int ec;
        logic ea;
    } vec_t;
    vec_t tbl[$];

    bit m_cov[N];
    bit m_pend[N];
    int m_ptr, m_cnt, m_mode, m_held;

    toggle_cover_scheduler #(.N(N), .COVER_INDEX(CI), .IDX_W(64), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .valid(valid),
        .clear_req(clear_req),
        .clear_ack(clear_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .covered_count(covered_count),
        .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    function automatic bit m_any();
        for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < N; k++) if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return m_ptr;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_cov[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_ptr = 0;
        m_cnt = 0;
        m_mode = 0;
        m_held = -1;
    endtask

    // mode: 0 run, 1 drain, 2 clear
    task automatic model_step(input logic r, input logic [N-1:0] v, input logic cr, input logic rdy);
        bit ov;
        int s;
        if (r || m_mode == 2) begin
            m_clear();
        end else begin
            ov = m_any();
            s = (m_held >= 0) ? m_held : m_pick();
            if (ov && rdy) begin
                m_pend[s] = 1'b0;
                m_ptr = (s + 1) % N;
                m_held = -1;
            end else begin
                m_held = ov ? s : -1;
            end
            if (m_mode == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (v[i] && !m_cov[i]) begin
                        m_cov[i] = 1'b1;
                        m_pend[i] = 1'b1;
                        m_cnt++;
                    end
                end
                if (cr) m_mode = 1;
            end else if (!m_any()) begin
                m_mode = 2;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic cr, input logic rdy);
        reset = r;
        valid = v;
        clear_req = cr;
        out_ready = rdy;
        @(posedge clock);
        #1;
        model_step(r, v, cr, rdy);
    endtask

    task automatic check(input string name, input logic ev, input int ei, input int ec, input logic ea);
        logic [63:0] exp_idx;
        logic exp_all;
        exp_idx = 64'(CI) + 64'(ei);
        exp_all = (ec == N);
        vectors++;
        if (out_valid !== ev || out_index !== exp_idx || covered_count !== CNT_W'(ec) ||
            clear_ack !== ea || all_covered !== exp_all) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b index=%0d count=%0d ack=%0b all=%0b, want valid=%0b index=%0d count=%0d ack=%0b all=%0b",
                     name, out_valid, out_index, covered_count, clear_ack, all_covered,
                     ev, exp_idx, ec, ea, exp_all);
        end
    endtask

    task automatic check_model(input string name);
        logic ev;
        ev = m_any() && m_mode != 2;
        check(name, ev, ev ? ((m_held >= 0) ? m_held : m_pick()) : m_ptr, m_cnt, m_mode == 2);
    endtask

    task automatic add(input logic r, input logic [N-1:0] v, input logic cr, input logic rdy,
                       input logic ev, input int ei, input int ec, input logic ea);
        vec_t t;
        t.rst = r; t.v = v; t.cr = cr; t.rdy = rdy;
        t.ev = ev; t.ei = ei; t.ec = ec; t.ea = ea;
        tbl.push_back(t);
    endtask

    initial begin
        logic [N-1:0] rv;
        m_clear();
        // reset, with valid ignored during reset
        add(1, 20'h00000, 0, 0, 0, 0, 0, 0);
        add(1, 20'h00010, 0, 0, 0, 0, 0, 0);
        // single hit
        add(0, 20'h00010, 0, 1, 1, 4, 1, 0);
        add(0, 20'h00000, 0, 1, 0, 5, 1, 0);
        // duplicate suppression of bit 3
        add(0, 20'h00008, 0, 0, 1, 3, 2, 0);
        add(0, 20'h00008, 0, 1, 0, 4, 2, 0);
        add(0, 20'h00000, 0, 1, 0, 4, 2, 0);
        add(0, 20'h00000, 0, 1, 0, 4, 2, 0);
        add(0, 20'h00008, 0, 1, 0, 4, 2, 0);
        // round robin with stall
        add(1, 20'h00000, 0, 0, 0, 0, 0, 0);
        add(0, 20'h80003, 0, 0, 1, 0, 3, 0);
        add(0, 20'h00000, 0, 0, 1, 0, 3, 0);
        add(0, 20'h00000, 0, 0, 1, 0, 3, 0);
        add(0, 20'h00000, 0, 0, 1, 0, 3, 0);
        add(0, 20'h00000, 0, 1, 1, 1, 3, 0);
        add(0, 20'h00000, 0, 1, 1, 19, 3, 0);
        add(0, 20'h00000, 0, 1, 0, 0, 3, 0);
        add(0, 20'h00004, 0, 1, 1, 2, 4, 0);
        add(0, 20'h00000, 0, 1, 0, 3, 4, 0);
        // stalled offer must not be preempted by a closer new hit
        add(0, 20'h00400, 0, 0, 1, 10, 5, 0);
        add(0, 20'h00080, 0, 0, 1, 10, 6, 0);
        add(0, 20'h00000, 0, 1, 1, 7, 6, 0);
        add(0, 20'h00000, 0, 1, 0, 8, 6, 0);
        // drain then clear, hit during drain ignored
        add(1, 20'h00000, 0, 0, 0, 0, 0, 0);
        add(0, 20'h0001F, 1, 0, 1, 0, 5, 0);
        add(0, 20'h00400, 0, 0, 1, 0, 5, 0);
        add(0, 20'h00000, 0, 1, 1, 1, 5, 0);
        add(0, 20'h00000, 0, 1, 1, 2, 5, 0);
        add(0, 20'h00000, 0, 1, 1, 3, 5, 0);
        add(0, 20'h00000, 0, 1, 1, 4, 5, 0);
        add(0, 20'h00000, 0, 1, 0, 5, 5, 1);
        add(0, 20'h00000, 0, 1, 0, 0, 0, 0);
        add(0, 20'h00400, 0, 1, 1, 10, 1, 0);
        add(0, 20'h00000, 0, 1, 0, 11, 1, 0);
        // reset mid-operation, hit during reset dropped
        add(0, 20'h00007, 0, 0, 1, 0, 4, 0);
        add(1, 20'h00100, 0, 0, 0, 0, 0, 0);
        add(0, 20'h00000, 0, 1, 0, 0, 0, 0);
        // reset mid-drain gives no ack
        add(0, 20'h00003, 1, 0, 1, 0, 2, 0);
        add(1, 20'h00000, 0, 0, 0, 0, 0, 0);
        add(0, 20'h00000, 0, 0, 0, 0, 0, 0);
        // level clear_req with nothing pending restarts a drain after returning to run
        add(0, 20'h00000, 1, 1, 0, 0, 0, 0);
        add(0, 20'h00000, 1, 1, 0, 0, 0, 1);
        add(0, 20'h00000, 1, 1, 0, 0, 0, 0);
        add(0, 20'h00000, 1, 1, 0, 0, 0, 0);
        add(0, 20'h00000, 0, 1, 0, 0, 0, 1);
        add(0, 20'h00000, 0, 1, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].cr, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ec, tbl[i].ea);
        end
        // full coverage in one cycle, then twenty consecutive events
        step(1, '0, 0, 1);
        step(0, '1, 0, 1);
        check("full0", 1, 0, N, 0);
        for (int i = 1; i < N; i++) begin
            step(0, '0, 0, 1);
            check($sformatf("full%0d", i), 1, i, N, 0);
        end
        step(0, '0, 0, 1);
        check("full_done", 0, 0, N, 0);
        // randomized traffic against the reference model
        step(1, '0, 0, 0);
        check_model("rand_reset");
        for (int c = 0; c < 1500; c++) begin
            rv = N'($urandom & $urandom & $urandom);
            step($urandom_range(0, 149) == 0, rv, $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
            check_model($sformatf("rand%0d", c));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/toggle_cover_scheduler.md
Name: toggle_cover_scheduler

Overview:
- Sits between a bank of N toggle-cover valid bits and a single cover-event export port, which is a DPI or formal sink consuming one index per handshake.
- Records first hits in a sticky bitmap.
- Queues each newly covered bit once and emits the queued indices one per cycle on a valid/ready stream, using round-robin order.
- Provides a drain-then-clear command so the testbench can reset coverage between fuzzing runs without losing queued events.

Parameters:
- N, 20, number of toggle points in the bank.
- COVER_INDEX, 0, global index of bit 0; emitted index = COVER_INDEX + bit.
- IDX_W, 64, width of the emitted index (matches longint cover index).
- CNT_W, $clog2(N+1), width of covered_count.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- valid  in  N  per-bit toggle hit this cycle.
- clear_req  in  1  level request to drain pending events and then clear coverage.
- clear_ack  out  1  one-cycle pulse when the clear completes.
- out_valid  out  1  an event index is presented.
- out_ready  in  1  sink accepts the event.
- out_index  out  IDX_W  COVER_INDEX + selected bit.
- covered_count  out  CNT_W  number of distinct bits covered since the last clear/reset.
- all_covered  out  1  covered_count == N.

Behaviour:
- State registers: covered[N], pending[N], ptr (index 0..N-1), covered_count, and an FSM with states RUN, DRAIN, CLEAR.
- Reset (synchronous, reset=1 at posedge): covered=0, pending=0, ptr=0, count=0, FSM=RUN.
  - Outputs during and after reset: out_valid=0, clear_ack=0, all_covered=0, out_index=COVER_INDEX.
  - valid is ignored in any cycle where reset=1.
  - A reset asserted mid-DRAIN discards pending events and returns to RUN. No clear_ack is issued.
- New-hit logic, applied only in RUN:
  - new = valid & ~covered.
  - covered |= valid; pending |= new; count += popcount(new).
  - All updates take effect in the next cycle, so there is 1-cycle latency from valid to out_valid.
- A bit already covered never re-enters pending. Each bit therefore produces exactly one event per clear epoch.
- In DRAIN and CLEAR, valid is ignored entirely: no update to covered, pending or count.
- Selection:
  - sel = first set bit of pending searching from ptr upward, wrapping from N-1 to 0.
  - out_valid = |pending and FSM != CLEAR.
  - out_index = COVER_INDEX + zero-extended sel. When out_valid=0, out_index holds COVER_INDEX + ptr.
  - out_index and out_valid are combinational from registers only, not from valid or out_ready.
- Handshake (out_valid & out_ready):
  - clears pending[sel]; ptr = (sel == N-1) ? 0 : sel+1.
  - While out_valid=1 and out_ready=0, out_index must remain stable. The new-hit logic may set other pending bits, but sel must not change.
    - Implementation rule: the selection is latched while stalled, i.e. held until the handshake.
  - Same-cycle set and clear of one bit cannot occur, since a pending bit is already covered.
- FSM transitions:
  - RUN -> DRAIN when clear_req=1. Hits in that same cycle are still recorded.
  - DRAIN -> CLEAR when pending==0, or when the last pending bit is handshaken this cycle.
  - CLEAR lasts one cycle: covered=0, pending=0, count=0, ptr=0; clear_ack=1 in this cycle; next state RUN. valid is ignored in CLEAR.
  - In RUN, clear_req is edge-insensitive: if still high after returning to RUN, a new drain starts on the next cycle.
- Count arithmetic:
  - count saturates naturally at N, because new is masked by ~covered.
  - all_covered is registered-equivalent, i.e. a compare of the register.

Decomposition:
- Shared package toggle_cover_pkg: FSM state enum (RUN, DRAIN, CLEAR), the default IDX_W constant, and a popcount function.
- One sub-module is natural: rr_pick (N-bit request vector + ptr -> sel, any).
  - It is reusable by other cover-bank schedulers.

Test Plan:
- Single hit: reset, then valid=20'h00010 for 1 cycle with out_ready=1.
  - Next cycle: out_valid=1, out_index=COVER_INDEX+4.
  - Following cycle: out_valid=0, covered_count=1.
- Duplicate suppression: valid=bit3 on cycles 1, 2 and 5 -> exactly one event, index 3; count=1.
- Round-robin and stall: valid=20'h80003 in one cycle with out_ready=0 for 3 cycles.
  - During the stall: index 0 is held stable.
  - Then ready=1: events in order 0, 1, 19; ptr ends at 0; count=3.
  - Then valid=bit2: event 2.
- Full coverage: valid=20'hFFFFF in one cycle, ready=1.
  - 20 events over 20 cycles, indices 0..19.
  - covered_count=20 and all_covered=1 from the cycle after the hit.
- Drain/clear: 5 bits pending, ready=0, clear_req pulse; then valid=bit10 during DRAIN; then ready=1.
  - Exactly 5 events, then clear_ack pulse.
  - count=0; bit10 was not recorded.
  - A subsequent valid=bit10 yields event 10.
- Reset mid-operation: 3 events pending, assert reset for 1 cycle.
  - out_valid=0 and count=0 next cycle; no clear_ack.
  - valid asserted during the reset cycle produces no event.
